// File: rtl/instruction_sequencer.sv
// instruction_sequencer: multi-cycle FETCH/DECODE/EXEC/MEMWAIT/WB controller for the opcode decoder.
// Optional single-step start input is enabled by defining SEQ_SINGLE_STEP_EN.
module instruction_sequencer #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic               step,
`endif
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [3:0]         OpCode,
    input  logic [13:0]        F,
    output logic [13:0]        ctrl,
    output logic               wb_en,
    input  logic               mem_busy,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic               halted,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXEC    = 3'd3,
        S_MEMWAIT = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    state_t             r_state;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [13:0]        r_cw;
    logic               r_imem_req;
    logic [13:0]        r_ctrl;
    logic               r_wb_en;
    logic               r_halted;

    logic w_start;
    logic w_continue;

`ifdef SEQ_SINGLE_STEP_EN
    logic r_step_d;
    logic w_step_rise;
    logic w_run_unused;

    assign w_step_rise  = step & ~r_step_d;
    assign w_start      = w_step_rise;
    assign w_continue   = 1'b0;
    assign w_run_unused = run;
`else
    assign w_start    = run;
    assign w_continue = run;
`endif

    // Operand bits of IR belong to the datapath side; only the opcode is consumed here.
    logic w_ir_unused;
    assign w_ir_unused = ^r_ir[INSTR_W-5:0];

    assign imem_req  = r_imem_req;
    assign imem_addr = r_pc;
    assign OpCode    = r_ir[INSTR_W-1 -: 4];
    assign ctrl      = r_ctrl;
    assign wb_en     = r_wb_en;
    assign halted    = r_halted;
    assign state     = r_state;

    // NOTE: outputs are updated together with the state transition (non-blocking), so each one is a flop that changes in lockstep with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_ir       <= '0;
            r_cw       <= '0;
            r_imem_req <= 1'b0;
            r_ctrl     <= '0;
            r_wb_en    <= 1'b0;
            r_halted   <= 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
            r_step_d   <= 1'b0;
`endif
        end else begin
`ifdef SEQ_SINGLE_STEP_EN
            r_step_d <= step;
`endif
            r_wb_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state    <= S_FETCH;
                        r_imem_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_ir       <= imem_data;
                        r_imem_req <= 1'b0;
                        r_state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_cw    <= F;
                    r_ctrl  <= F;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (r_cw[13]) begin
                        r_ctrl   <= '0;
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else if (r_cw[12]) begin
                        r_state <= S_MEMWAIT;
                    end else begin
                        r_ctrl  <= '0;
                        r_wb_en <= 1'b1;
                        r_state <= S_WB;
                    end
                end
                S_MEMWAIT: begin
                    if (!mem_busy) begin
                        r_ctrl  <= '0;
                        r_wb_en <= 1'b1;
                        r_state <= S_WB;
                    end
                end
                S_WB: begin
                    if (r_cw[11] && branch_taken) begin
                        r_pc <= branch_target;
                    end else begin
                        r_pc <= r_pc + PC_W'(1);
                    end
                    if (w_continue) begin
                        r_imem_req <= 1'b1;
                        r_state    <= S_FETCH;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_ctrl     <= '0;
                    r_imem_req <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed testbench for instruction_sequencer: memory responder with programmable ack delay and a table-driven decoder stub.
`timescale 1ns/1ps
module tb_instruction_sequencer;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_MEMWAIT = 3'd4;
    localparam logic [2:0] S_WB      = 3'd5;
    localparam logic [2:0] S_HALT    = 3'd6;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               run = 1'b0;
    logic               imem_ack = 1'b0;
    logic [INSTR_W-1:0] imem_data = '0;
    logic               mem_busy = 1'b0;
    logic               branch_taken = 1'b0;
    logic [PC_W-1:0]    branch_target = '0;
`ifdef SEQ_SINGLE_STEP_EN
    logic               step = 1'b0;
`endif

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [3:0]         OpCode;
    logic [13:0]        F;
    logic [13:0]        ctrl;
    logic               wb_en;
    logic               halted;
    logic [2:0]         state;

    logic [INSTR_W-1:0] mem [0:255];
    logic [13:0]        f_table [0:15];
    int                 ack_delay = 0;
    int                 wait_cnt = 0;

    int n_cmp = 0;
    int n_err = 0;

    assign F = f_table[OpCode];

    instruction_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
`ifdef SEQ_SINGLE_STEP_EN
        .step          (step),
`endif
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .OpCode        (OpCode),
        .F             (F),
        .ctrl          (ctrl),
        .wb_en         (wb_en),
        .mem_busy      (mem_busy),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halted        (halted),
        .state         (state)
    );

    always #5 clk = ~clk;

    // Instruction memory: acks on the negedge after ack_delay waiting cycles of a request.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end else if (imem_req) begin
            if (wait_cnt >= ack_delay) begin
                imem_ack  = 1'b1;
                imem_data = mem[imem_addr];
                wait_cnt  = 0;
            end else begin
                imem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int k;
        k = 0;
        while (state !== s && k < budget) begin
            tick();
            k++;
        end
        n_cmp++;
        if (state !== s) begin
            n_err++;
            $display("FAIL %s: state=%0d, expected %0d within %0d cycles", tag, state, s, budget);
        end
    endtask

    task automatic run_instr(input string tag);
        run = 1'b1;
        tick();
        run = 1'b0;
        wait_state(S_IDLE, 30, tag);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        repeat (2) tick();
        n_cmp++; if ({imem_req, wb_en, halted} !== 3'b000) begin n_err++; $display("FAIL reset_flags: req/wb/halt=%b expected 000", {imem_req, wb_en, halted}); end
        n_cmp++; if (ctrl !== 14'h0) begin n_err++; $display("FAIL reset_ctrl: got %h expected 0000", ctrl); end
        n_cmp++; if (OpCode !== 4'h0) begin n_err++; $display("FAIL reset_opcode: got %h expected 0", OpCode); end
        #3 rst_n = 1'b1;
        tick();
        n_cmp++; if (state !== S_IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", state, S_IDLE); end
        n_cmp++; if (imem_addr !== 8'h00) begin n_err++; $display("FAIL reset_pc: got %h expected 00", imem_addr); end
    endtask

    task automatic test_basic();
        mem[0] = 16'h1234; f_table[1] = 14'h0005;
        mem[1] = 16'h2000; f_table[2] = 14'h0000;
        ack_delay = 0;
        run = 1'b1;
        tick();
        n_cmp++; if ({state, imem_req, imem_addr} !== {S_FETCH, 1'b1, 8'h00}) begin n_err++; $display("FAIL basic_fetch: state=%0d req=%b addr=%h expected 1/1/00", state, imem_req, imem_addr); end
        tick();
        n_cmp++; if ({state, OpCode, imem_req} !== {S_DECODE, 4'h1, 1'b0}) begin n_err++; $display("FAIL basic_decode: state=%0d op=%h req=%b expected 2/1/0", state, OpCode, imem_req); end
        n_cmp++; if (ctrl !== 14'h0) begin n_err++; $display("FAIL basic_decode_ctrl: got %h expected 0000", ctrl); end
        tick();
        n_cmp++; if ({state, ctrl, wb_en} !== {S_EXEC, 14'h0005, 1'b0}) begin n_err++; $display("FAIL basic_exec: state=%0d ctrl=%h wb=%b expected 3/0005/0", state, ctrl, wb_en); end
        tick();
        n_cmp++; if ({state, ctrl, wb_en} !== {S_WB, 14'h0000, 1'b1}) begin n_err++; $display("FAIL basic_wb: state=%0d ctrl=%h wb=%b expected 5/0000/1", state, ctrl, wb_en); end
        tick();
        n_cmp++; if ({state, imem_req, imem_addr, wb_en} !== {S_FETCH, 1'b1, 8'h01, 1'b0}) begin n_err++; $display("FAIL basic_refetch: state=%0d req=%b addr=%h wb=%b expected 1/1/01/0", state, imem_req, imem_addr, wb_en); end
        run = 1'b0;
        wait_state(S_IDLE, 10, "basic_stop");
        n_cmp++; if (imem_addr !== 8'h02) begin n_err++; $display("FAIL basic_pc: got %h expected 02", imem_addr); end
    endtask

    task automatic test_ack_delay();
        mem[2] = 16'h3abc; f_table[3] = 14'h0011;
        ack_delay = 3;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if ({state, imem_req, imem_addr} !== {S_FETCH, 1'b1, 8'h02}) begin n_err++; $display("FAIL delay_fetch_%0d: state=%0d req=%b addr=%h expected 1/1/02", i, state, imem_req, imem_addr); end
            tick();
        end
        n_cmp++; if ({state, imem_req, OpCode} !== {S_DECODE, 1'b0, 4'h3}) begin n_err++; $display("FAIL delay_decode: state=%0d req=%b op=%h expected 2/0/3", state, imem_req, OpCode); end
        tick();
        n_cmp++; if (ctrl !== 14'h0011) begin n_err++; $display("FAIL delay_exec_ctrl: got %h expected 0011", ctrl); end
        ack_delay = 0;
        wait_state(S_IDLE, 10, "delay_stop");
        n_cmp++; if (imem_addr !== 8'h03) begin n_err++; $display("FAIL delay_pc: got %h expected 03", imem_addr); end
    endtask

    task automatic test_memwait();
        int busy_left;
        int mw_cnt;
        bit got_wb;
        mem[3] = 16'h4000; f_table[4] = 14'h1003;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        n_cmp++; if ({state, ctrl} !== {S_EXEC, 14'h1003}) begin n_err++; $display("FAIL mw_exec: state=%0d ctrl=%h expected 3/1003", state, ctrl); end
        // busy spans EXEC plus four MEMWAIT cycles: five cycles high in total
        mem_busy  = 1'b1;
        busy_left = 5;
        mw_cnt    = 0;
        got_wb    = 1'b0;
        for (int i = 0; i < 20 && !got_wb; i++) begin
            tick();
            if (state === S_MEMWAIT) begin
                mw_cnt++;
                n_cmp++; if (ctrl !== 14'h1003) begin n_err++; $display("FAIL mw_ctrl_%0d: got %h expected 1003", mw_cnt, ctrl); end
                busy_left--;
                if (busy_left == 0) mem_busy = 1'b0;
            end else begin
                got_wb = 1'b1;
            end
        end
        mem_busy = 1'b0;
        n_cmp++; if (mw_cnt != 5) begin n_err++; $display("FAIL mw_count: got %0d MEMWAIT cycles expected 5", mw_cnt); end
        n_cmp++; if ({state, wb_en, ctrl} !== {S_WB, 1'b1, 14'h0}) begin n_err++; $display("FAIL mw_wb: state=%0d wb=%b ctrl=%h expected 5/1/0000", state, wb_en, ctrl); end
        wait_state(S_IDLE, 10, "mw_stop");
        n_cmp++; if (imem_addr !== 8'h04) begin n_err++; $display("FAIL mw_pc: got %h expected 04", imem_addr); end
    endtask

    task automatic test_branch();
        f_table[5] = 14'h0800;
        f_table[6] = 14'h0001;
        mem[8'h04] = 16'h5000; branch_taken = 1'b1; branch_target = 8'h40;
        run_instr("br_taken_stop");
        n_cmp++; if (imem_addr !== 8'h40) begin n_err++; $display("FAIL br_taken: pc=%h expected 40", imem_addr); end
        mem[8'h40] = 16'h5000; branch_taken = 1'b0;
        run_instr("br_not_taken_stop");
        n_cmp++; if (imem_addr !== 8'h41) begin n_err++; $display("FAIL br_not_taken: pc=%h expected 41", imem_addr); end
        mem[8'h41] = 16'h5000; branch_taken = 1'b1; branch_target = 8'hFF;
        run_instr("br_to_ff_stop");
        n_cmp++; if (imem_addr !== 8'hFF) begin n_err++; $display("FAIL br_to_ff: pc=%h expected ff", imem_addr); end
        // no BRANCH bit: branch_taken must be ignored and pc wraps
        mem[8'hFF] = 16'h6000; branch_taken = 1'b1; branch_target = 8'h40;
        run_instr("br_wrap_stop");
        n_cmp++; if (imem_addr !== 8'h00) begin n_err++; $display("FAIL br_wrap: pc=%h expected 00", imem_addr); end
        branch_taken = 1'b0;
    endtask

    task automatic test_halt();
        mem[0] = 16'h6000;
        mem[1] = 16'h7000; f_table[7] = 14'h2000;
        run = 1'b1;
        tick();
        wait_state(S_HALT, 20, "halt_reach");
        n_cmp++; if ({halted, imem_req, ctrl} !== {1'b1, 1'b0, 14'h0}) begin n_err++; $display("FAIL halt_outputs: halted=%b req=%b ctrl=%h expected 1/0/0000", halted, imem_req, ctrl); end
        for (int i = 0; i < 6; i++) begin
            run = i[0];
            tick();
            n_cmp++; if ({state, imem_req, halted} !== {S_HALT, 1'b0, 1'b1}) begin n_err++; $display("FAIL halt_hold_%0d: state=%0d req=%b halted=%b expected 6/0/1", i, state, imem_req, halted); end
        end
        run = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({halted, state, imem_addr} !== {1'b0, S_IDLE, 8'h00}) begin n_err++; $display("FAIL halt_reset: halted=%b state=%0d pc=%h expected 0/0/00", halted, state, imem_addr); end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_async_reset();
        mem[0] = 16'h6000;
        run_instr("ar_prep_stop");
        ack_delay = 100;
        run = 1'b1;
        tick();
        n_cmp++; if ({state, imem_req, imem_addr} !== {S_FETCH, 1'b1, 8'h01}) begin n_err++; $display("FAIL ar_fetch: state=%0d req=%b addr=%h expected 1/1/01", state, imem_req, imem_addr); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({state, imem_req, imem_addr} !== {S_IDLE, 1'b0, 8'h00}) begin n_err++; $display("FAIL ar_fetch_reset: state=%0d req=%b addr=%h expected 0/0/00", state, imem_req, imem_addr); end
        ack_delay = 0;
        #2 rst_n = 1'b1;
        tick();
        n_cmp++; if ({state, imem_req, imem_addr} !== {S_FETCH, 1'b1, 8'h00}) begin n_err++; $display("FAIL ar_restart: state=%0d req=%b addr=%h expected 1/1/00", state, imem_req, imem_addr); end
        run = 1'b0;
        wait_state(S_IDLE, 20, "ar_restart_stop");

        mem[1] = 16'h4000;
        mem_busy = 1'b1;
        run = 1'b1;
        tick();
        run = 1'b0;
        wait_state(S_MEMWAIT, 10, "ar_mw_reach");
        n_cmp++; if (ctrl !== 14'h1003) begin n_err++; $display("FAIL ar_mw_ctrl: got %h expected 1003", ctrl); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({state, ctrl, imem_addr} !== {S_IDLE, 14'h0, 8'h00}) begin n_err++; $display("FAIL ar_mw_reset: state=%0d ctrl=%h addr=%h expected 0/0000/00", state, ctrl, imem_addr); end
        #2 rst_n = 1'b1;
        mem_busy = 1'b0;
        run = 1'b1;
        tick();
        n_cmp++; if ({state, imem_req, imem_addr} !== {S_FETCH, 1'b1, 8'h00}) begin n_err++; $display("FAIL ar_mw_restart: state=%0d req=%b addr=%h expected 1/1/00", state, imem_req, imem_addr); end
        run = 1'b0;
        wait_state(S_IDLE, 20, "ar_mw_restart_stop");
    endtask

`ifdef SEQ_SINGLE_STEP_EN
    task automatic test_single_step();
        mem[0] = 16'h6000; f_table[6] = 14'h0001;
        run  = 1'b1;
        step = 1'b0;
        repeat (3) tick();
        n_cmp++; if (state !== S_IDLE) begin n_err++; $display("FAIL ss_run_only: state=%0d expected 0", state); end
        step = 1'b1;
        tick();
        n_cmp++; if ({state, imem_addr} !== {S_FETCH, 8'h00}) begin n_err++; $display("FAIL ss_start: state=%0d addr=%h expected 1/00", state, imem_addr); end
        wait_state(S_IDLE, 20, "ss_stop");
        repeat (4) tick();
        n_cmp++; if ({state, imem_addr} !== {S_IDLE, 8'h01}) begin n_err++; $display("FAIL ss_one_only: state=%0d pc=%h expected 0/01", state, imem_addr); end
        step = 1'b0;
        run  = 1'b0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int i = 0; i < 16; i++) f_table[i] = '0;
        test_reset();
`ifdef SEQ_SINGLE_STEP_EN
        test_single_step();
`else
        test_basic();
        test_ack_delay();
        test_memwait();
        test_branch();
        test_halt();
        test_async_reset();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
